riscv_divider: RTL and testbench

- Multi-cycle RV32M divide unit for DIV, DIVU, REM and REMU.
- Sits between operand read and writeback. It takes rs1/rs2 values and the rd index from decode/register read.
- Drives a one-cycle write request (enable_write_rd, rd_index, rd) into the register file.
- Core stalls PC update while busy is high.

---
 rtl/riscv_divider_pkg.sv | 37 +++
 rtl/riscv_divider_if.sv | 26 ++
 rtl/riscv_div_core.sv | 68 ++++++
 rtl/riscv_divider.sv | 144 ++++++++++++++
 tb/tb_riscv_divider.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_divider_pkg.sv
// Shared definitions for the RV32M divide unit: widths, M-extension encodings,
// operation and FSM state enums, and small op-decoding helpers.
package riscv_divider_pkg;

  localparam int DIV_XLEN        = 32;
  localparam int DIV_REG_INDEX_W = 5;
  localparam int REG_COUNT       = 32;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  // Low two bits of funct3 select the operation.
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/riscv_divider_if.sv
// Request/writeback bundle between decode/register-read, the divider and the register file.
interface riscv_divider_if #(
  parameter int XLEN        = 32,
  parameter int REG_INDEX_W = 5
);
  logic                   start;
  logic                   kill;
  logic [1:0]             op;
  logic [XLEN-1:0]        src1;
  logic [XLEN-1:0]        src2;
  logic [REG_INDEX_W-1:0] dst_index;
  logic                   busy;
  logic                   enable_write_rd;
  logic [REG_INDEX_W-1:0] rd_index;
  logic [XLEN-1:0]        rd;

  modport master (
    output start, kill, op, src1, src2, dst_index,
    input  busy, enable_write_rd, rd_index, rd
  );

  modport slave (
    input  start, kill, op, src1, src2, dst_index,
    output busy, enable_write_rd, rd_index, rd
  );
endinterface

// File: rtl/riscv_div_core.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, MSB first,
// XLEN iterations after start. Results are valid the cycle after done.
module riscv_div_core #(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int                CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);

  logic             active;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  divisor_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN:0]    partial;
  logic [XLEN:0]    trial;
  logic             fits;

  // quo_q starts as the dividend and shifts quotient bits in from the right
  // as dividend bits leave from the left, so one register serves both roles.
  always_comb begin
    partial = {rem_q, quo_q[XLEN-1]};
    trial   = partial - {1'b0, divisor_q};
    fits    = ~trial[XLEN];
  end

  // High during the final iteration; quotient/remainder settle on that edge.
  assign done = active && (count == LAST_CNT);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, matching real flip-flops.
  always_ff @(posedge clock) begin
    if (!reset) begin
      active    <= 1'b0;
      count     <= '0;
      divisor_q <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
    end else if (abort) begin
      active <= 1'b0;
    end else if (start) begin
      active    <= 1'b1;
      count     <= '0;
      divisor_q <= divisor;
      rem_q     <= '0;
      quo_q     <= dividend;
    end else if (active) begin
      rem_q <= fits ? trial[XLEN-1:0] : partial[XLEN-1:0];
      quo_q <= {quo_q[XLEN-2:0], fits};
      count <= count + 1'b1;
      if (done) active <= 1'b0;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/riscv_divider.sv
// RV32M DIV/DIVU/REM/REMU unit: sign handling, special cases, flush and
// register-file writeback around the unsigned iterative core.
module riscv_divider
  import riscv_divider_pkg::*;
#(
  parameter int XLEN        = DIV_XLEN,
  parameter int REG_INDEX_W = DIV_REG_INDEX_W
) (
  input logic             clock,
  input logic             reset,
  riscv_divider_if.slave  bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e             state, state_next;
  logic                   accept;
  logic                   write_now;

  div_op_e                op_q;
  logic [REG_INDEX_W-1:0] dst_q;
  logic                   q_neg_q;
  logic                   r_neg_q;
  logic                   special_q;
  logic [XLEN-1:0]        special_res_q;
  logic                   busy_q;
  logic                   wr_q;
  logic [REG_INDEX_W-1:0] rd_index_q;
  logic [XLEN-1:0]        rd_q;

  logic                   src1_neg, src2_neg;
  logic [XLEN-1:0]        src1_mag, src2_mag;
  logic                   div_by_zero, overflow, special;
  logic [XLEN-1:0]        special_res;

  logic                   core_done;
  logic [XLEN-1:0]        core_quo, core_rem;
  logic [XLEN-1:0]        quo_signed, rem_signed, result;

  // Operand conditioning on the request inputs; only sampled on acceptance.
  always_comb begin
    src1_neg    = op_is_signed(bus.op) & bus.src1[XLEN-1];
    src2_neg    = op_is_signed(bus.op) & bus.src2[XLEN-1];
    src1_mag    = src1_neg ? -bus.src1 : bus.src1;
    src2_mag    = src2_neg ? -bus.src2 : bus.src2;
    div_by_zero = (bus.src2 == '0);
    overflow    = op_is_signed(bus.op) && (bus.src1 == MIN_NEG) && (bus.src2 == '1);
    special     = div_by_zero | overflow;
    if (div_by_zero) special_res = op_is_rem(bus.op) ? bus.src1 : '1;
    else             special_res = op_is_rem(bus.op) ? '0 : MIN_NEG;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path through
  // the case leaves a signal unassigned and a latch is never inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    write_now  = 1'b0;
    if (bus.kill) begin
      state_next = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.start && !busy_q) begin
            accept     = 1'b1;
            state_next = special ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: if (core_done) state_next = ST_DONE;
        ST_DONE: begin
          write_now  = 1'b1;
          state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  riscv_div_core #(.XLEN(XLEN)) u_core (
    .clock     (clock),
    .reset     (reset),
    .start     (accept && !special),
    .abort     (bus.kill),
    .dividend  (src1_mag),
    .divisor   (src2_mag),
    .done      (core_done),
    .quotient  (core_quo),
    .remainder (core_rem)
  );

  always_comb begin
    quo_signed = q_neg_q ? -core_quo : core_quo;
    rem_signed = r_neg_q ? -core_rem : core_rem;
    if (special_q)            result = special_res_q;
    else if (op_is_rem(op_q)) result = rem_signed;
    else                      result = quo_signed;
  end

  // NOTE: the writeback registers are reset because they drive the register
  // file port directly and must read as zero after reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      op_q          <= OP_DIV;
      dst_q         <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      special_q     <= 1'b0;
      special_res_q <= '0;
      busy_q        <= 1'b0;
      wr_q          <= 1'b0;
      rd_index_q    <= '0;
      rd_q          <= '0;
    end else begin
      wr_q <= write_now;
      if (accept) begin
        op_q          <= div_op_e'(bus.op);
        dst_q         <= bus.dst_index;
        q_neg_q       <= src1_neg ^ src2_neg;
        r_neg_q       <= src1_neg;
        special_q     <= special;
        special_res_q <= special_res;
      end
      if (write_now) begin
        rd_q       <= result;
        rd_index_q <= dst_q;
      end
      // busy covers the strobe cycle too, so it drops one edge after wr_q.
      if (bus.kill)    busy_q <= 1'b0;
      else if (accept) busy_q <= 1'b1;
      else if (wr_q)   busy_q <= 1'b0;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.enable_write_rd = wr_q;
  assign bus.rd_index        = rd_index_q;
  assign bus.rd              = rd_q;

endmodule

// File: tb/tb_riscv_divider.sv
// Scoreboard bench for riscv_divider: directed corner cases plus random
// operations checked against an arithmetic reference of the RV32M rules.
module tb_riscv_divider;
  import riscv_divider_pkg::*;

  localparam int XLEN = DIV_XLEN;
  localparam int IW   = DIV_REG_INDEX_W;
  localparam logic [XLEN-1:0] MIN_NEG = 32'h8000_0000;

  typedef struct {
    logic [IW-1:0]   idx;
    logic [XLEN-1:0] value;
    int unsigned     due;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int unsigned cyc   = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];

  riscv_divider_if #(.XLEN(XLEN), .REG_INDEX_W(IW)) bus();

  riscv_divider #(.XLEN(XLEN), .REG_INDEX_W(IW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RISC-V M semantics from plain 64-bit arithmetic; the wide type absorbs
  // the -2^31 / -1 overflow, whose truncation gives the architected result.
  function automatic logic [XLEN-1:0] ref_result(input logic [1:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (b == '0) return op[1] ? a : '1;
    case (op)
      2'b00:   r = sa / sb;
      2'b01:   r = ua / ub;
      2'b10:   r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[XLEN-1:0];
  endfunction

  function automatic int unsigned ref_latency(input logic [1:0] op,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    if (b == '0) return 1;
    if (!op[0] && a == MIN_NEG && b == '1) return 1;
    return XLEN + 1;
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (bus.enable_write_rd) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(bus.rd_index), 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rd", 64'(bus.rd), 64'(e.value));
        check("rd_index", 64'(bus.rd_index), 64'(e.idx));
        check("wb_cycle", 64'(cyc), 64'(e.due));
      end
    end
  end

  task automatic wait_idle();
    @(negedge clock);
    for (int i = 0; i < 200 && bus.busy; i++) @(negedge clock);
    if (bus.busy) check("idle_timeout", 64'(bus.busy), 64'd0);
  endtask

  // Issues one request; on return we sit at the negedge after the accepting edge.
  task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [IW-1:0] idx,
                        input bit expect_wb);
    wait_idle();
    bus.start     = 1'b1;
    bus.op        = op;
    bus.src1      = a;
    bus.src2      = b;
    bus.dst_index = idx;
    if (expect_wb)
      exp_q.push_back('{idx: idx, value: ref_result(op, a, b),
                        due: cyc + 1 + ref_latency(op, a, b)});
    @(negedge clock);
    bus.start     = 1'b0;
    bus.op        = 2'($urandom);
    bus.src1      = $urandom;
    bus.src2      = $urandom;
    bus.dst_index = IW'($urandom);
    check("busy_after_accept", 64'(bus.busy), 64'd1);
  endtask

  task automatic wait_strobe_then_idle();
    int n = 0;
    while (!bus.enable_write_rd && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (!bus.enable_write_rd) check("strobe_timeout", 64'd0, 64'd1);
    @(negedge clock);
    check("busy_after_wb", 64'(bus.busy), 64'd0);
  endtask

  function automatic logic [XLEN-1:0] pick_operand();
    case ($urandom_range(0, 9))
      0:       return '0;
      1:       return '1;
      2:       return MIN_NEG;
      3:       return XLEN'($urandom_range(1, 16));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = 2'b00;
    bus.src1 = '0; bus.src2 = '0; bus.dst_index = '0;
    repeat (3) @(negedge clock);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_wr", 64'(bus.enable_write_rd), 64'd0);
    check("reset_rd_index", 64'(bus.rd_index), 64'd0);
    check("reset_rd", 64'(bus.rd), 64'd0);
    reset = 1'b1;

    run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b1);          wait_strobe_then_idle();
    run_op(OP_REMU, 32'd100, 32'd7, 5'd5, 1'b1);          wait_strobe_then_idle();
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 1'b1);     wait_strobe_then_idle();
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 1'b1);     wait_strobe_then_idle();
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd8, 1'b1);     wait_strobe_then_idle();
    run_op(OP_DIVU, 32'd1234, 32'd0, 5'd9, 1'b1);         wait_strobe_then_idle();
    run_op(OP_REM, MIN_NEG, 32'd0, 5'd10, 1'b1);          wait_strobe_then_idle();
    run_op(OP_DIV, MIN_NEG, 32'hFFFF_FFFF, 5'd11, 1'b1);  wait_strobe_then_idle();
    run_op(OP_REM, MIN_NEG, 32'hFFFF_FFFF, 5'd12, 1'b1);  wait_strobe_then_idle();
    run_op(OP_DIVU, MIN_NEG, 32'hFFFF_FFFF, 5'd13, 1'b1); wait_strobe_then_idle();
    run_op(OP_DIVU, 32'd50, 32'd5, 5'd0, 1'b1);           wait_strobe_then_idle();

    // A second start while busy must not disturb the operation in flight.
    run_op(OP_DIVU, 32'd1000, 32'd3, 5'd14, 1'b1);
    repeat (8) @(negedge clock);
    bus.start = 1'b1; bus.op = OP_REMU; bus.src1 = 32'd77; bus.src2 = 32'd5; bus.dst_index = 5'd15;
    @(negedge clock);
    bus.start = 1'b0;
    wait_strobe_then_idle();

    // Flush during CALC: no strobe, busy drops on the next edge.
    run_op(OP_DIV, 32'd12345, 32'd11, 5'd16, 1'b0);
    repeat (18) @(negedge clock);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    check("busy_after_kill", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clock);
    run_op(OP_REM, 32'd12345, 32'd11, 5'd17, 1'b1);       wait_strobe_then_idle();

    // Flush while in DONE after a special case must also suppress the write.
    run_op(OP_DIVU, 32'd5, 32'd0, 5'd18, 1'b0);
    bus.kill = 1'b1;
    @(negedge clock);
    bus.kill = 1'b0;
    check("busy_after_done_kill", 64'(bus.busy), 64'd0);
    check("wr_after_done_kill", 64'(bus.enable_write_rd), 64'd0);
    repeat (3) @(negedge clock);

    // Reset mid-operation clears everything with no write.
    run_op(OP_DIVU, 32'd999, 32'd4, 5'd19, 1'b0);
    repeat (13) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_busy", 64'(bus.busy), 64'd0);
    check("midreset_wr", 64'(bus.enable_write_rd), 64'd0);
    check("midreset_rd_index", 64'(bus.rd_index), 64'd0);
    check("midreset_rd", 64'(bus.rd), 64'd0);
    reset = 1'b1;
    repeat (40) @(negedge clock);

    for (int i = 0; i < 1500; i++)
      run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), IW'($urandom), 1'b1);

    wait_idle();
    repeat (3) @(negedge clock);
    check("pending_expectations", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
